// File: rtl/banked_main_mem.sv
// rtl/banked_main_mem.sv - four-bank interleaved word memory with fixed-latency reads
//
// Purpose:
//   Main memory behind the cache controller. Bank = addr[2:1], so the four
//   consecutive words of a line fill land in banks 0..3 without conflict.
//   A request to a busy bank is refused (stall). An illegal request is
//   ignored (err). Read data returns exactly two cycles after accept.
//
// Ports:
//   i_clk        clock, all state updates on the rising edge
//   i_rst        synchronous active-high reset (array contents kept)
//   i_addr       byte address, bit 0 must be 0, bank = i_addr[2:1]
//   i_data_in    write data
//   i_wr, i_rd   write / read request (one request per cycle)
//   o_data_out   read data, 16'h0000 unless o_data_valid
//   o_data_valid read data returning this cycle
//   o_stall      presented request refused, its bank is busy
//   o_busy       per-bank occupancy
//   o_err        presented request illegal and ignored (or internal fault)

module banked_main_mem #(
    parameter int MEM_WORDS   = 32768,
    parameter int BANK_CYCLES = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_data_in,
    input  logic        i_wr,
    input  logic        i_rd,
    output logic [15:0] o_data_out,
    output logic        o_data_valid,
    output logic        o_stall,
    output logic [3:0]  o_busy,
    output logic        o_err
);

    localparam int          AW       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [16:0] LP_WORDS = 17'(MEM_WORDS);
    localparam logic [2:0]  LP_LOAD  = 3'(BANK_CYCLES - 1);

    logic [15:0]   r_mem [MEM_WORDS];
    logic [2:0]    r_cnt [4];
    logic          r_int_err;
    logic          r_s1_valid;
    logic [15:0]   r_s1_data;
    logic          r_s2_valid;
    logic [15:0]   r_s2_data;

    logic [1:0]    w_bank;
    logic [AW-1:0] w_idx;
    logic          w_req;
    logic          w_req_err;
    logic          w_cnt_bad;
    logic          w_err;
    logic          w_accept;

    assign w_bank = i_addr[2:1];
    assign w_idx  = i_addr[AW:1];
    assign w_req  = i_rd | i_wr;

    // Range test is done on the full 15-bit word index so out-of-range
    // addresses never alias onto a legal word through the truncated index.
    assign w_req_err = w_req & ((i_rd & i_wr) | i_addr[0] |
                                ({2'b00, i_addr[15:1]} >= LP_WORDS));

    always_comb begin
        w_cnt_bad = 1'b0;
        for (int b = 0; b < 4; b++) begin
            o_busy[b] = (r_cnt[b] != 3'd0);
            if (r_cnt[b] > LP_LOAD) begin
                w_cnt_bad = 1'b1;
            end
        end
    end

    // A corrupted counter latches err until reset; it also blocks accepts.
    assign w_err    = w_req_err | r_int_err | w_cnt_bad;
    assign o_err    = w_err;
    assign o_stall  = w_req & ~w_err & o_busy[w_bank];
    assign w_accept = w_req & ~w_err & ~o_stall;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int b = 0; b < 4; b++) begin
                r_cnt[b] <= 3'd0;
            end
            r_int_err  <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_data  <= 16'h0000;
            r_s2_valid <= 1'b0;
            r_s2_data  <= 16'h0000;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (w_accept && (w_bank == 2'(b))) begin
                    r_cnt[b] <= LP_LOAD;
                end else if (r_cnt[b] != 3'd0) begin
                    r_cnt[b] <= r_cnt[b] - 3'd1;
                end
            end
            r_int_err  <= r_int_err | w_cnt_bad;
            r_s1_valid <= w_accept & i_rd;
            r_s1_data  <= (w_accept & i_rd) ? r_mem[w_idx] : 16'h0000;
            r_s2_valid <= r_s1_valid;
            r_s2_data  <= r_s1_data;
        end
    end

    // Array has no reset; writes are suppressed while reset is asserted.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_accept && i_wr) begin
            r_mem[w_idx] <= i_data_in;
        end
    end

    assign o_data_valid = r_s2_valid;
    assign o_data_out   = r_s2_valid ? r_s2_data : 16'h0000;

endmodule

// File: doc/banked_main_mem.md
Name: banked_main_mem

Overview:
- Four-bank, word-addressed main memory that sits directly downstream of the cache controller.
- Consumes the controller's addr/data/wr/rd stream during write-back and line fill, and returns fill data with fixed latency.
- Banks are interleaved on addr[2:1], so the controller's four consecutive offset requests (0,2,4,6) hit banks 0..3 with no conflict.
- Exposes per-bank busy and a stall so illegal back-to-back same-bank requests are refused, not corrupted.

Parameters:
- MEM_WORDS, 32768: number of 16-bit words; valid word index = addr[15:1] < MEM_WORDS.
- BANK_CYCLES, 4: cycles a bank is occupied per accepted access, including the accept cycle; legal range 3..7.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- addr  input  16  byte address; addr[0] must be 0; bank = addr[2:1].
- data_in  input  16  write data.
- wr  input  1  write request.
- rd  input  1  read request.
- data_out  output  16  read data; valid only in the cycle data_valid=1, else 16'h0000.
- data_valid  output  1  read data returning this cycle.
- stall  output  1  the presented request is refused this cycle because its bank is busy.
- busy  output  4  busy[b]=1 while bank b is occupied.
- err  output  1  the presented request is illegal and is ignored.

Behaviour:
- Reset, sampled at a clock edge:
  - busy counters cleared, so busy=4'b0000.
  - Read pipeline flushed, so data_valid=0 and data_out=16'h0000.
  - stall=0 and err=0 once rd=wr=0.
  - Array contents are not cleared.
  - Reset mid-operation drops in-flight reads with no data_valid pulse, and releases all banks.
- Request evaluation is combinational in cycle N:
  - req = rd|wr.
  - err = req & ((rd&wr) | addr[0] | (addr[15:1] >= MEM_WORDS)).
  - stall = req & ~err & busy[addr[2:1]].
  - accept = req & ~err & ~stall.
- err has priority over stall. An err or stalled request changes no state; the requester must hold or retry.
- Accepted write: mem[addr[15:1]] <= data_in at the end of cycle N. A read of the same word accepted in any later cycle sees the new value.
- Accepted read:
  - Array word is sampled at the end of cycle N.
  - data_valid=1 and data_out=that word in cycle N+2 exactly; fixed latency 2, no early or late return.
  - Reads to different banks accepted in N and N+1 return in N+2 and N+3, in issue order.
- Bank occupancy:
  - A per-bank down-counter (3 bits) loads BANK_CYCLES-1 at the end of accept cycle N.
  - busy[b] = (counter != 0), so busy is high in N+1 .. N+BANK_CYCLES-1.
  - The bank can accept again in cycle N+BANK_CYCLES.
  - Counters decrement to 0 and saturate there.
- Simultaneous events:
  - Only one request per cycle (single port).
  - A returning read in cycle N+2 and a new accept in the same cycle are independent.
  - A counter reaching 0 at an edge makes busy=0 in the next cycle. No same-cycle bypass: a request in the last busy cycle stalls.
- Internal state:
  - 4 bank counters.
  - Two-stage read pipeline holding {valid, data}.
  - Memory array.
- No FSM beyond the counters.
- Any internal illegal condition (counter > BANK_CYCLES-1) raises err until reset.

Test Plan:
- Reset then idle: rst=1 for 1 cycle, then rd=wr=0 → busy=0000, stall=0, err=0, data_valid=0, data_out=0000 every cycle.
- Write then read:
  - wr addr=16'h0010 data=16'hBEEF in cycle 1 → busy=0001 in cycles 2-4.
  - rd addr=16'h0010 in cycle 5 is accepted → data_valid=1, data_out=BEEF in cycle 7.
- Line-fill sweep: rd at addr 16'h0020,22,24,26 in cycles 1-4 (preloaded 1111,2222,3333,4444) → stall=0 throughout; data_out=1111,2222,3333,4444 with data_valid=1 in cycles 3-6.
- Bank conflict:
  - rd addr=16'h0000 in cycle 1, then rd addr=16'h0008 (same bank 0) held in cycles 2-4 → stall=1 in cycles 2-4.
  - Accepted cycle 5, data returned cycle 7; the first read returns in cycle 3.
- Errors, each ignored with no state change:
  - rd=wr=1 → err=1, busy unchanged.
  - addr=16'h0011 → err=1.
  - addr=16'hFFFE with MEM_WORDS=1024 → err=1.
- Reset mid-read: rd accepted in cycle 1, rst=1 in cycle 2 → data_valid=0 in cycle 3, busy=0000 in cycle 3.
